// File: rtl/riscv_register_memory.sv
// EX/MEM boundary register with a two-entry skid buffer: one-cycle latency, full throughput.
// o_ready comes from registered state only, so a memory-stage stall never reaches execute combinationally.
module riscv_register_memory #(
  parameter int              XLEN          = 32,
  parameter logic [XLEN-1:0] REGISTER_INIT = '0
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_alu_result,
  input  logic [XLEN-1:0] i_store_data,
  input  logic [XLEN-1:0] i_pc,
  input  logic [4:0]      i_rd,
  input  logic            i_rd_we,
  input  logic            i_mem_re,
  input  logic            i_mem_we,
  input  logic [2:0]      i_mem_size,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_alu_result,
  output logic [XLEN-1:0] o_store_data,
  output logic [XLEN-1:0] o_pc,
  output logic [4:0]      o_rd,
  output logic            o_rd_we,
  output logic            o_mem_re,
  output logic            o_mem_we,
  output logic [2:0]      o_mem_size
);

  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic            rd_we;
    logic            mem_re;
    logic            mem_we;
    logic [2:0]      mem_size;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  localparam entry_t ENTRY_INIT = '{
    alu_result: REGISTER_INIT,
    store_data: REGISTER_INIT,
    pc:         REGISTER_INIT,
    rd:         REGISTER_INIT[4:0],
    rd_we:      1'b0,
    mem_re:     1'b0,
    mem_we:     1'b0,
    mem_size:   REGISTER_INIT[2:0]
  };

  state_t state, next_state;
  entry_t main_q, skid_q, captured;
  logic   accept, issue;
  logic   load_main, load_main_from_skid, load_skid;

  assign o_ready = (state != SKID);
  assign o_valid = (state != EMPTY);
  assign accept  = i_valid & o_ready;
  assign issue   = o_valid & i_ready;

  // Writes to x0 are dropped here so later stages never see a spurious writeback.
  always_comb begin
    captured.alu_result = i_alu_result;
    captured.store_data = i_store_data;
    captured.pc         = i_pc;
    captured.rd         = i_rd;
    captured.rd_we      = i_rd_we & (i_rd != 5'd0);
    captured.mem_re     = i_mem_re;
    captured.mem_we     = i_mem_we;
    captured.mem_size   = i_mem_size;
  end

  always_comb begin
    next_state          = state;
    load_main           = 1'b0;
    load_main_from_skid = 1'b0;
    load_skid           = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          next_state = FULL;
          load_main  = 1'b1;
        end
      end
      FULL: begin
        if (accept && issue) begin
          load_main = 1'b1;
        end else if (accept) begin
          next_state = SKID;
          load_skid  = 1'b1;
        end else if (issue) begin
          next_state = EMPTY;
        end
      end
      SKID: begin
        if (issue) begin
          next_state          = FULL;
          load_main_from_skid = 1'b1;
        end
      end
      default: next_state = EMPTY;
    endcase
    // A squash discards the incoming entry too; payload keeps its old value.
    if (i_flush) begin
      next_state          = EMPTY;
      load_main           = 1'b0;
      load_main_from_skid = 1'b0;
      load_skid           = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      main_q <= ENTRY_INIT;
      skid_q <= ENTRY_INIT;
    end else begin
      if (load_main) begin
        main_q <= captured;
      end else if (load_main_from_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= captured;
      end
    end
  end

  assign o_alu_result = main_q.alu_result;
  assign o_store_data = main_q.store_data;
  assign o_pc         = main_q.pc;
  assign o_rd         = main_q.rd;
  assign o_mem_size   = main_q.mem_size;
  assign o_rd_we      = main_q.rd_we  & o_valid;
  assign o_mem_re     = main_q.mem_re & o_valid;
  assign o_mem_we     = main_q.mem_we & o_valid;

endmodule

// File: tb/tb_riscv_register_memory.sv
// Directed bench for riscv_register_memory: handshake, skid ordering, capture rule, flush and async reset.
module tb_riscv_register_memory;

  localparam int XLEN = 32;

  logic            i_clk = 1'b0;
  logic            i_rstn;
  logic            i_flush;
  logic            i_valid;
  logic            o_ready;
  logic [XLEN-1:0] i_alu_result;
  logic [XLEN-1:0] i_store_data;
  logic [XLEN-1:0] i_pc;
  logic [4:0]      i_rd;
  logic            i_rd_we;
  logic            i_mem_re;
  logic            i_mem_we;
  logic [2:0]      i_mem_size;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_alu_result;
  logic [XLEN-1:0] o_store_data;
  logic [XLEN-1:0] o_pc;
  logic [4:0]      o_rd;
  logic            o_rd_we;
  logic            o_mem_re;
  logic            o_mem_we;
  logic [2:0]      o_mem_size;

  int checks = 0;
  int errors = 0;

  riscv_register_memory #(.XLEN(XLEN), .REGISTER_INIT('0)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_alu_result(i_alu_result), .i_store_data(i_store_data), .i_pc(i_pc), .i_rd(i_rd),
    .i_rd_we(i_rd_we), .i_mem_re(i_mem_re), .i_mem_we(i_mem_we), .i_mem_size(i_mem_size),
    .o_valid(o_valid), .i_ready(i_ready), .o_alu_result(o_alu_result), .o_store_data(o_store_data),
    .o_pc(o_pc), .o_rd(o_rd), .o_rd_we(o_rd_we), .o_mem_re(o_mem_re), .o_mem_we(o_mem_we),
    .o_mem_size(o_mem_size)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic offer(input logic valid, input logic [XLEN-1:0] alu, input logic [XLEN-1:0] sdata,
                       input logic [4:0] rd, input logic rd_we, input logic mem_re,
                       input logic mem_we, input logic [2:0] size);
    i_valid      = valid;
    i_alu_result = alu;
    i_store_data = sdata;
    i_pc         = alu + 32'h1000;
    i_rd         = rd;
    i_rd_we      = rd_we;
    i_mem_re     = mem_re;
    i_mem_we     = mem_we;
    i_mem_size   = size;
  endtask

  initial begin
    i_rstn  = 1'b0;
    i_flush = 1'b0;
    i_ready = 1'b0;
    offer(1'b0, '0, '0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    #3;
    check("reset_valid", o_valid, 0);
    check("reset_ready", o_ready, 1);
    check("reset_alu", o_alu_result, 0);
    check("reset_rd_we", o_rd_we, 0);
    tick();
    tick();
    i_rstn = 1'b1;

    // Single entry, one-cycle latency
    i_ready = 1'b1;
    offer(1'b1, 32'h100, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'd0);
    tick();
    check("first_valid", o_valid, 1);
    check("first_alu", o_alu_result, 32'h100);
    check("first_pc", o_pc, 32'h1100);
    check("first_rd", o_rd, 5);
    check("first_rd_we", o_rd_we, 1);
    check("first_ready", o_ready, 1);
    offer(1'b0, '0, '0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    check("first_drain_valid", o_valid, 0);
    check("first_drain_rd_we", o_rd_we, 0);
    check("first_drain_alu_hold", o_alu_result, 32'h100);

    // Back-to-back stream with i_ready high
    for (int k = 1; k <= 8; k++) begin
      offer(1'b1, XLEN'(k), '0, 5'd1, 1'b1, 1'b0, 1'b0, 3'd0);
      tick();
      check("stream_valid", o_valid, 1);
      check("stream_alu", o_alu_result, 64'(k));
      check("stream_ready", o_ready, 1);
    end
    offer(1'b0, '0, '0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    check("stream_drain_valid", o_valid, 0);

    // Stall: A held on output, B in skid, then released in order
    i_ready = 1'b0;
    offer(1'b1, 32'hA, '0, 5'd2, 1'b1, 1'b0, 1'b0, 3'd0);
    tick();
    check("stall_a_alu", o_alu_result, 32'hA);
    check("stall_a_ready", o_ready, 1);
    offer(1'b1, 32'hB, '0, 5'd3, 1'b1, 1'b0, 1'b0, 3'd0);
    tick();
    check("stall_skid_alu", o_alu_result, 32'hA);
    check("stall_skid_ready", o_ready, 0);
    offer(1'b0, '0, '0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    check("stall_hold_alu", o_alu_result, 32'hA);
    check("stall_hold_ready", o_ready, 0);
    i_ready = 1'b1;
    tick();
    check("release_b_valid", o_valid, 1);
    check("release_b_alu", o_alu_result, 32'hB);
    check("release_b_rd", o_rd, 3);
    check("release_ready", o_ready, 1);
    tick();
    check("release_drain_valid", o_valid, 0);

    // x0 write suppression and store pass-through
    offer(1'b1, 32'h40, '0, 5'd0, 1'b1, 1'b0, 1'b0, 3'd0);
    tick();
    check("x0_valid", o_valid, 1);
    check("x0_rd_we", o_rd_we, 0);
    offer(1'b1, 32'h2000, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b1, 3'b010);
    tick();
    check("store_mem_we", o_mem_we, 1);
    check("store_mem_re", o_mem_re, 0);
    check("store_data", o_store_data, 32'hDEADBEEF);
    check("store_size", o_mem_size, 3'b010);
    check("store_addr", o_alu_result, 32'h2000);
    offer(1'b1, 32'h3000, '0, 5'd9, 1'b1, 1'b1, 1'b0, 3'b100);
    tick();
    check("load_mem_re", o_mem_re, 1);
    check("load_rd_we", o_rd_we, 1);
    offer(1'b0, '0, '0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    check("ls_drain_mem_re", o_mem_re, 0);

    // Flush while in SKID with i_ready high
    i_ready = 1'b0;
    offer(1'b1, 32'h11, 32'h1, 5'd4, 1'b0, 1'b0, 1'b1, 3'b010);
    tick();
    offer(1'b1, 32'h22, 32'h2, 5'd4, 1'b0, 1'b0, 1'b1, 3'b010);
    tick();
    check("flush_pre_ready", o_ready, 0);
    check("flush_pre_mem_we", o_mem_we, 1);
    offer(1'b1, 32'h33, 32'h3, 5'd4, 1'b0, 1'b0, 1'b1, 3'b010);
    i_flush = 1'b1;
    i_ready = 1'b1;
    tick();
    i_flush = 1'b0;
    offer(1'b0, '0, '0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    check("flush_valid", o_valid, 0);
    check("flush_mem_we", o_mem_we, 0);
    check("flush_ready", o_ready, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("flush_no_issue", o_valid, 0);
    end

    // Async reset mid-stall with both entries held
    i_ready = 1'b0;
    offer(1'b1, 32'h44, 32'h55, 5'd7, 1'b1, 1'b0, 1'b1, 3'b001);
    tick();
    offer(1'b1, 32'h66, 32'h77, 5'd8, 1'b1, 1'b1, 1'b0, 3'b101);
    tick();
    offer(1'b0, '0, '0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    check("rst_pre_ready", o_ready, 0);
    #2;
    i_rstn = 1'b0;
    #1;
    check("arst_valid", o_valid, 0);
    check("arst_ready", o_ready, 1);
    check("arst_alu", o_alu_result, 0);
    check("arst_store", o_store_data, 0);
    check("arst_rd", o_rd, 0);
    check("arst_rd_we", o_rd_we, 0);
    check("arst_mem_we", o_mem_we, 0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    tick();
    check("post_rst_valid", o_valid, 0);
    i_ready = 1'b1;
    offer(1'b1, 32'h88, '0, 5'd6, 1'b1, 1'b0, 1'b0, 3'd0);
    tick();
    check("post_rst_alu", o_alu_result, 32'h88);
    check("post_rst_issue_valid", o_valid, 1);
    offer(1'b0, '0, '0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    check("post_rst_drain_valid", o_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_register_memory.md
Name: riscv_register_memory

Overview:
- EX/MEM pipeline boundary register: captures execute-stage results and presents them to the memory stage.
- Unlike the plain stage register, it provides a valid/ready handshake on both sides, so the memory stage (e.g. a waiting data bus) can stall execute without losing an instruction.
- Two-entry skid buffer gives full throughput; synchronous flush supports branch/exception squash.

Parameters:
- XLEN, 32, datapath width of result, store data and PC fields.
- REGISTER_INIT, 0, reset value of all payload output registers.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset, asynchronous, active-low
- i_flush  in  1  synchronous squash of all held entries
- i_valid  in  1  execute stage presents an instruction
- o_ready  out  1  block can accept this cycle
- i_alu_result  in  XLEN  ALU result / effective address
- i_store_data  in  XLEN  rs2 data for stores
- i_pc  in  XLEN  instruction PC
- i_rd  in  5  destination register index
- i_rd_we  in  1  register writeback enable
- i_mem_re  in  1  load
- i_mem_we  in  1  store
- i_mem_size  in  3  funct3 of load/store
- o_valid  out  1  entry presented to memory stage
- i_ready  in  1  memory stage accepts this cycle
- o_alu_result, o_store_data, o_pc  out  XLEN  head-entry payload
- o_rd  out  5; o_rd_we, o_mem_re, o_mem_we  out  1; o_mem_size  out  3  head-entry control

Behaviour:
- Accept = i_valid & o_ready; issue = o_valid & i_ready. Both evaluated on the same rising edge.
- Storage: main register (drives outputs) and skid register. State machine: EMPTY, FULL (main valid), SKID (main and skid valid).
- o_ready = (state != SKID), decoded from registered state only; no combinational path from i_ready. o_valid = (state != EMPTY).
- Transitions:
  - EMPTY: accept -> FULL, main <= input.
  - FULL: accept & issue -> FULL, main <= input. Accept only -> SKID, skid <= input. Issue only -> EMPTY. Neither -> hold.
  - SKID: issue -> FULL, main <= skid. Otherwise hold. No accept is possible in SKID.
- Latency: accepted entry appears on outputs the next cycle when the block was EMPTY or the head issued. Sustained throughput: 1 entry/cycle with i_ready held high. Order is strictly FIFO.
- Capture rule: stored rd_we = i_rd_we & (i_rd != 0). Stores and loads are passed unchanged.
- Side-effect gating: o_rd_we, o_mem_re and o_mem_we are ANDed with o_valid, so they are never 1 while o_valid = 0. Other payload outputs hold their last value when invalid.
- Flush: i_flush = 1 -> next state EMPTY regardless of accept/issue in the same cycle. The input that cycle is discarded, o_valid = 0 and o_ready = 1 the next cycle. Payload registers are not cleared.
- Reset (async, any state, mid-operation): state EMPTY, o_valid 0, o_ready 1, all payload outputs REGISTER_INIT, gated enables 0. Release is synchronous to i_clk.
- Input contract: while i_valid = 1 and o_ready = 0, upstream holds the payload stable. Output contract: while o_valid = 1 and i_ready = 0, outputs are held stable.

Test Plan:
- Reset, then i_valid = 1 with alu = 0x100, rd = 5, rd_we = 1, i_ready = 1 -> next cycle o_valid = 1, o_alu_result = 0x100, o_rd_we = 1; o_ready stays 1.
- Stream 8 back-to-back entries (alu = 1..8) with i_ready = 1 -> outputs 1..8 on consecutive cycles, no bubbles.
- i_ready = 0 while entries A and B are offered -> A held on outputs, B goes to skid, o_ready = 0. Raise i_ready -> A then B issued in order, o_ready returns to 1.
- Entry with i_rd = 0, i_rd_we = 1 -> o_rd_we = 0. Store (mem_we = 1, store_data = 0xDEADBEEF, size = 3'b010) -> passed through.
- In SKID state, assert i_flush together with i_ready = 1 -> next cycle o_valid = 0, o_mem_we = 0, o_ready = 1, and no later issue of either entry.
- Assert i_rstn = 0 asynchronously mid-stall with both entries held -> o_valid drops immediately, payload = REGISTER_INIT; after release the first new accept issues normally.
